// File: rtl/burst_word_demux_pkg.sv
// Shared definitions for the burst word demux: default widths, FSM state
// encodings and the next-state helper used by the top level.
package burst_word_demux_pkg;

  // Default geometry, shared with the memory array.
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int LEN_W_DEF  = 3;

  // FSM state encodings (legacy-compatible 2-bit constants).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Next state from the current state and the two handshakes. An unused
  // encoding falls back to IDLE so a corrupted state register self-recovers.
  function automatic logic [1:0] fsm_next(
    input logic [1:0] state,
    input logic       cmd_acc,
    input logic       beat_acc,
    input logic       last_beat
  );
    logic [1:0] nxt;
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_acc) begin
          nxt = ST_BURST;
        end else begin
          nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (beat_acc && last_beat) begin
          nxt = ST_DONE;
        end else begin
          nxt = ST_BURST;
        end
      end
      ST_DONE: begin
        nxt = ST_IDLE;
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/burst_word_demux_onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable. All-zero output when
// the enable is low. Also used as the read-side mux select decoder.
module burst_word_demux_onehot_dec #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] bin,
  output logic [DEPTH-1:0]  onehot
);

  // Place a single set bit at position bin when enabled.
  always_comb begin
    onehot = {DEPTH{1'b0}};
    if (en) begin
      onehot = {{(DEPTH-1){1'b0}}, 1'b1} << bin;
    end else begin
      onehot = {DEPTH{1'b0}};
    end
  end

endmodule

// File: rtl/burst_word_demux.sv
// Burst word demux: accepts a (start address, beat count) command, then
// steers each accepted data beat to one memory word via a registered one-hot
// write-enable, auto-incrementing the address with wrap-around.
module burst_word_demux
  import burst_word_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  output logic [DEPTH-1:0]  word_we,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  cnt_r;
  logic [DEPTH-1:0]  word_we_r;
  logic [DATA_W-1:0] wdata_r;
  logic              req_ready_r;
  logic              din_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              cmd_acc_s;
  logic              beat_acc_s;
  logic              last_beat_s;
  logic [DEPTH-1:0]  dec_s;

  // Handshake qualification is gated by state, so inputs seen in the wrong
  // state (req_valid mid-burst, din_valid outside BURST) have no effect.
  always_comb begin
    cmd_acc_s   = req_valid & (state_r == ST_IDLE);
    beat_acc_s  = din_valid & (state_r == ST_BURST);
    last_beat_s = (cnt_r == {LEN_W{1'b0}});
    state_nxt_s = fsm_next(state_r, cmd_acc_s, beat_acc_s, last_beat_s);
  end

  burst_word_demux_onehot_dec #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dec (
    .en     (beat_acc_s),
    .bin    (addr_r),
    .onehot (dec_s)
  );

  // FSM state plus the address and remaining-beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      cnt_r   <= {LEN_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (cmd_acc_s) begin
        addr_r <= req_addr;
        cnt_r  <= req_len;
      end else if (beat_acc_s) begin
        // Natural overflow gives the DEPTH-1 -> 0 wrap.
        addr_r <= addr_r + ADDR_W'(1);
        if (!last_beat_s) begin
          cnt_r <= cnt_r - LEN_W'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        addr_r <= addr_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  // Write-enable and write-data registers; wdata keeps its last value
  // whenever no beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_we_r <= {DEPTH{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
    end else begin
      word_we_r <= dec_s;
      if (beat_acc_s) begin
        wdata_r <= din;
      end else begin
        wdata_r <= wdata_r;
      end
    end
  end

  // Status flags registered from the next state, so each flag equals a pure
  // decode of the current state with no input-to-output combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b1;
      din_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      din_ready_r <= (state_nxt_s == ST_BURST);
      busy_r      <= (state_nxt_s == ST_BURST) | (state_nxt_s == ST_DONE);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign req_ready = req_ready_r;
  assign din_ready = din_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign word_we   = word_we_r;
  assign wdata     = wdata_r;

endmodule

// File: tb/tb_burst_word_demux.sv
// Directed self-checking bench for burst_word_demux: default geometry plus a
// wider-parameter instance for the long wrapping burst.
module tb_burst_word_demux;

  logic clk;
  logic rst_n;

  // Default-parameter instance
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_addr;
  logic [2:0] req_len;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] din;
  logic [7:0] word_we;
  logic [7:0] wdata;
  logic       busy;
  logic       done;

  // ADDR_W=4, DATA_W=16, LEN_W=5 instance
  logic        w_req_valid;
  logic        w_req_ready;
  logic [3:0]  w_req_addr;
  logic [4:0]  w_req_len;
  logic        w_din_valid;
  logic        w_din_ready;
  logic [15:0] w_din;
  logic [15:0] w_word_we;
  logic [15:0] w_wdata;
  logic        w_busy;
  logic        w_done;

  int checks;
  int errors;

  burst_word_demux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .word_we   (word_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  burst_word_demux #(
    .DATA_W (16),
    .ADDR_W (4),
    .LEN_W  (5)
  ) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (w_req_valid),
    .req_ready (w_req_ready),
    .req_addr  (w_req_addr),
    .req_len   (w_req_len),
    .din_valid (w_din_valid),
    .din_ready (w_din_ready),
    .din       (w_din),
    .word_we   (w_word_we),
    .wdata     (w_wdata),
    .busy      (w_busy),
    .done      (w_done)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle-state flag set of the default instance.
  task automatic chk_idle(input string tag);
    chk({tag, ".we"},   32'(word_we),   32'h0);
    chk({tag, ".done"}, 32'(done),      32'h0);
    chk({tag, ".busy"}, 32'(busy),      32'h0);
    chk({tag, ".rrdy"}, 32'(req_ready), 32'h1);
    chk({tag, ".drdy"}, 32'(din_ready), 32'h0);
  endtask

  logic [7:0] wrap_din [4];
  logic [7:0] wrap_we  [4];
  logic [7:0] st_valid [5];
  logic [7:0] st_din   [5];
  logic [7:0] st_we    [5];
  int         w_done_cnt;
  int         w_addr;

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = 3'd0;
    req_len     = 3'd0;
    din_valid   = 1'b0;
    din         = 8'h00;
    w_req_valid = 1'b0;
    w_req_addr  = 4'd0;
    w_req_len   = 5'd0;
    w_din_valid = 1'b0;
    w_din       = 16'h0000;

    // ---------------- reset ----------------
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk_idle("rst");
    chk("rst.wdata", 32'(wdata), 32'h0);

    // ---------------- single beat ----------------
    req_valid = 1'b1; req_addr = 3'd3; req_len = 3'd0;
    step();
    req_valid = 1'b0;
    chk("sb.drdy", 32'(din_ready), 32'h1);
    chk("sb.rrdy", 32'(req_ready), 32'h0);
    chk("sb.busy", 32'(busy),      32'h1);
    chk("sb.we0",  32'(word_we),   32'h0);
    din_valid = 1'b1; din = 8'hA5;
    step();
    din_valid = 1'b0;
    chk("sb.we",    32'(word_we),   32'h08);
    chk("sb.wdata", 32'(wdata),     32'hA5);
    chk("sb.done",  32'(done),      32'h1);
    chk("sb.drdyD", 32'(din_ready), 32'h0);
    step();
    chk_idle("sb.end");
    chk("sb.hold", 32'(wdata), 32'hA5);

    // ---------------- full-rate wrap burst ----------------
    wrap_din[0] = 8'h11; wrap_din[1] = 8'h22; wrap_din[2] = 8'h33; wrap_din[3] = 8'h44;
    wrap_we[0]  = 8'h40; wrap_we[1]  = 8'h80; wrap_we[2]  = 8'h01; wrap_we[3]  = 8'h02;
    req_valid = 1'b1; req_addr = 3'd6; req_len = 3'd3;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1; din = wrap_din[i];
      step();
      chk($sformatf("wr.we%0d", i),    32'(word_we), 32'(wrap_we[i]));
      chk($sformatf("wr.wd%0d", i),    32'(wdata),   32'(wrap_din[i]));
      chk($sformatf("wr.done%0d", i),  32'(done),    (i == 3) ? 32'h1 : 32'h0);
    end
    din_valid = 1'b0;
    step();
    chk_idle("wr.end");

    // ---------------- stalls and ignored inputs ----------------
    st_valid[0] = 8'd1; st_valid[1] = 8'd0; st_valid[2] = 8'd0; st_valid[3] = 8'd1; st_valid[4] = 8'd1;
    st_din[0]   = 8'h10; st_din[1]  = 8'hEE; st_din[2]  = 8'hEE; st_din[3]  = 8'h20; st_din[4]  = 8'h30;
    st_we[0]    = 8'h04; st_we[1]   = 8'h00; st_we[2]   = 8'h00; st_we[3]   = 8'h08; st_we[4]   = 8'h10;
    req_valid = 1'b1; req_addr = 3'd2; req_len = 3'd2;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din_valid = st_valid[i][0]; din = st_din[i];
      // A second command offered mid-burst must be ignored.
      req_valid = (i >= 1); req_addr = 3'd7; req_len = 3'd5;
      step();
      chk($sformatf("st.we%0d", i), 32'(word_we), 32'(st_we[i]));
      chk($sformatf("st.rr%0d", i), 32'(req_ready), 32'h0);
    end
    chk("st.wdata", 32'(wdata), 32'h30);
    chk("st.done",  32'(done),  32'h1);
    // Beat offered during DONE is dropped; req_valid still high here too.
    din_valid = 1'b1; din = 8'h99;
    step();
    req_valid = 1'b0; din_valid = 1'b0;
    chk_idle("st.end");
    chk("st.nowr", 32'(wdata), 32'h30);
    // Beat offered in IDLE is dropped and no command was queued.
    din_valid = 1'b1; din = 8'h77;
    step();
    din_valid = 1'b0;
    chk_idle("st.idle");
    chk("st.idlewd", 32'(wdata), 32'h30);

    // ---------------- reset mid-burst ----------------
    req_valid = 1'b1; req_addr = 3'd0; req_len = 3'd7;
    step();
    req_valid = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h50 + i);
      step();
    end
    chk("mr.we", 32'(word_we), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("mr.rst");
    chk("mr.wdata", 32'(wdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("mr.rel1");
    step();
    chk_idle("mr.rel2");
    din_valid = 1'b0;

    // ---------------- parameter sweep ----------------
    w_done_cnt  = 0;
    w_req_valid = 1'b1; w_req_addr = 4'd15; w_req_len = 5'd31;
    step();
    w_req_valid = 1'b0;
    chk("pw.drdy", 32'(w_din_ready), 32'h1);
    for (int i = 0; i < 32; i++) begin
      w_din_valid = 1'b1; w_din = 16'(16'h1000 + i);
      step();
      w_addr = (15 + i) % 16;
      chk($sformatf("pw.we%0d", i), 32'(w_word_we), 32'h1 << w_addr);
      chk($sformatf("pw.wd%0d", i), 32'(w_wdata),   32'h1000 + 32'(i));
      if (w_done) w_done_cnt++;
    end
    w_din_valid = 1'b0;
    step();
    if (w_done) w_done_cnt++;
    chk("pw.dcnt", 32'(w_done_cnt), 32'd1);
    chk("pw.we",   32'(w_word_we),  32'h0);
    chk("pw.rrdy", 32'(w_req_ready), 32'h1);
    chk("pw.busy", 32'(w_busy),      32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
